// File: rtl/generic_bus_mem_responder.sv
// generic_bus_mem_responder
//   Responder end of the generic CPU bus: a word-addressed RAM that accepts one
//   ren/wen request at a time from IDLE, waits WAIT_STATES cycles and then
//   presents a single-cycle response (busy low). Protocol and address errors
//   are latched into sticky flags that only reset clears. RAM contents are
//   deliberately not touched by reset so bench images survive a core reset.
module generic_bus_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] OOR_RDATA   = 32'hBAD1_BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  input  logic        ren,
  input  logic        wen,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        proto_err,
  output logic        oor_err
);

  localparam int          AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // In range iff BASE_ADDR <= a < BASE_ADDR + 4*DEPTH_WORDS. The subtraction
  // is done in 33 bits so an address below the base shows up as a borrow
  // instead of wrapping into the window.
  function automatic logic in_range_f(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return (off[32] == 1'b0) && (off < SPAN);
  endfunction

  // Word index within the RAM; the two byte-offset bits are dropped.
  function automatic logic [AW-1:0] index_f(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 32'd2);
  endfunction

  // Byte-lane merge: lanes with be=1 take the new data, others keep old.
  function automatic logic [31:0] merge_f(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  // Storage and state
  logic [31:0]   mem_q [DEPTH_WORDS];
  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          op_wr_q;
  logic          in_range_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic [31:0]   rdata_q;
  logic          busy_q;
  logic          proto_err_q;
  logic          oor_err_q;

  // Combinational helpers
  logic          accept_s;
  logic [AW-1:0] rd_idx_s;
  logic          rd_inr_s;
  logic          rd_is_read_s;
  logic          load_rdata_s;
  logic [31:0]   rd_word_s;

  assign accept_s = (state_q == ST_IDLE) && (ren || wen);

  // Next-state and wait-counter logic for IDLE -> (WAIT) -> RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          cnt_d = WS;
          if (WS != 4'd0) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // <= also catches a corrupted zero count so WAIT can never stall.
        if (cnt_q <= 4'd1) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Select which request drives the read port: the live bus when a zero-wait
  // read is accepted straight into RESP, otherwise the latched request.
  always_comb begin
    rd_idx_s     = idx_q;
    rd_inr_s     = in_range_q;
    rd_is_read_s = !op_wr_q;
    if (state_q == ST_IDLE) begin
      rd_idx_s     = index_f(addr);
      rd_inr_s     = in_range_f(addr);
      rd_is_read_s = ren && !wen;
    end else begin
      rd_idx_s     = idx_q;
      rd_inr_s     = in_range_q;
      rd_is_read_s = !op_wr_q;
    end
    load_rdata_s = (state_d == ST_RESP) && (state_q != ST_RESP) && rd_is_read_s;
    rd_word_s    = mem_q[rd_idx_s];
  end

  // Control registers, request latch, read-data register and sticky flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      op_wr_q     <= 1'b0;
      in_range_q  <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      rdata_q     <= 32'd0;
      busy_q      <= 1'b1;
      proto_err_q <= 1'b0;
      oor_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // busy is registered from the next state so it is low exactly while
      // the FSM sits in RESP.
      busy_q  <= (state_d != ST_RESP);
      if (accept_s) begin
        // ren&wen together is resolved as a write.
        op_wr_q    <= wen;
        in_range_q <= in_range_f(addr);
        idx_q      <= index_f(addr);
        wdata_q    <= wdata;
        be_q       <= byte_en;
        if (ren && wen) begin
          proto_err_q <= 1'b1;
        end
        if (!in_range_f(addr)) begin
          oor_err_q <= 1'b1;
        end
      end
      if (load_rdata_s) begin
        rdata_q <= rd_inr_s ? rd_word_s : OOR_RDATA;
      end
    end
  end

  // RAM write port: commits at the end of RESP; a reset on that same edge
  // discards the pending write.
  always_ff @(posedge CLK) begin
    if (!RST && (state_q == ST_RESP) && op_wr_q && in_range_q) begin
      mem_q[idx_q] <= merge_f(mem_q[idx_q], wdata_q, be_q);
    end
  end

  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign proto_err = proto_err_q;
  assign oor_err   = oor_err_q;

endmodule

// File: tb/tb_generic_bus_mem_responder.sv
// Bench for generic_bus_mem_responder: two instances (base 0 / 64 words /
// 2 wait states, and base 0x1000 / 16 words / 0 wait states) driven by
// directed scenarios and random transactions, checked against a word-array
// reference model of the memory, sticky flags and response latency.
module tb_generic_bus_mem_responder;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_1000;
  localparam int          DEP0  = 64;
  localparam int          DEP1  = 16;
  localparam int          WS0   = 2;
  localparam int          WS1   = 0;
  localparam logic [31:0] OOR   = 32'hBAD1_BAD1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     [2];
  logic [31:0] addr    [2];
  logic [31:0] wdata   [2];
  logic [3:0]  be      [2];
  logic        ren     [2];
  logic        wen     [2];
  logic [31:0] rdata   [2];
  logic        busy    [2];
  logic        perr    [2];
  logic        oerr    [2];

  generic_bus_mem_responder #(
    .BASE_ADDR(BASE0), .DEPTH_WORDS(DEP0), .WAIT_STATES(WS0), .OOR_RDATA(OOR)
  ) u_dut0 (
    .CLK(clk), .RST(rst[0]), .addr(addr[0]), .wdata(wdata[0]), .byte_en(be[0]),
    .ren(ren[0]), .wen(wen[0]), .rdata(rdata[0]), .busy(busy[0]),
    .proto_err(perr[0]), .oor_err(oerr[0])
  );

  generic_bus_mem_responder #(
    .BASE_ADDR(BASE1), .DEPTH_WORDS(DEP1), .WAIT_STATES(WS1), .OOR_RDATA(OOR)
  ) u_dut1 (
    .CLK(clk), .RST(rst[1]), .addr(addr[1]), .wdata(wdata[1]), .byte_en(be[1]),
    .ren(ren[1]), .wen(wen[1]), .rdata(rdata[1]), .busy(busy[1]),
    .proto_err(perr[1]), .oor_err(oerr[1])
  );

  // Reference model state
  logic [31:0] mdl     [2][64];
  logic [31:0] last_rd [2];
  logic        exp_perr[2];
  logic        exp_oerr[2];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic longint base_of(input int d);
    return (d == 0) ? longint'(BASE0) : longint'(BASE1);
  endfunction

  function automatic int depth_of(input int d);
    return (d == 0) ? DEP0 : DEP1;
  endfunction

  function automatic int ws_of(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  function automatic bit mdl_inr(input int d, input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (la >= base_of(d)) && (la < base_of(d) + 4 * depth_of(d));
  endfunction

  function automatic int mdl_idx(input int d, input logic [31:0] a);
    return int'((longint'(a) - base_of(d)) / 4);
  endfunction

  // Pulse reset on one instance and check the reset state.
  task automatic do_reset(input int d);
    @(negedge clk);
    rst[d] = 1'b1; ren[d] = 1'b0; wen[d] = 1'b0;
    @(negedge clk);
    exp_perr[d] = 1'b0; exp_oerr[d] = 1'b0; last_rd[d] = 32'd0;
    check($sformatf("rst_busy%0d", d), busy[d], 32'd1);
    check($sformatf("rst_rdata%0d", d), rdata[d], 32'd0);
    check($sformatf("rst_perr%0d", d), perr[d], 32'd0);
    check($sformatf("rst_oerr%0d", d), oerr[d], 32'd0);
    rst[d] = 1'b0;
  endtask

  // One complete transaction. When scramble is set, the bus is changed right
  // after the accept edge; the responder must ignore that.
  task automatic txn(input int d, input bit r, input bit w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] b, input bit scramble,
                     output logic [31:0] got_rd);
    int lat;
    int idx;
    bit inr;
    logic [31:0] exp_rd;
    @(negedge clk);
    addr[d] = a; wdata[d] = wd; be[d] = b; ren[d] = r; wen[d] = w;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        ren[d] = 1'b0; wen[d] = 1'b0;
        if (scramble) begin
          addr[d] = a ^ 32'h0000_0004; wdata[d] = $urandom; be[d] = 4'hF;
        end
      end
    end while (busy[d] !== 1'b0 && lat < 40);
    check($sformatf("latency%0d a=%08h", d, a), lat, 1 + ws_of(d));
    got_rd = rdata[d];
    inr = mdl_inr(d, a);
    idx = inr ? mdl_idx(d, a) : 0;
    if (r && !w) begin
      exp_rd = inr ? mdl[d][idx] : OOR;
      last_rd[d] = exp_rd;
      check($sformatf("rdata%0d a=%08h", d, a), rdata[d], exp_rd);
    end
    if (w && inr) begin
      for (int i = 0; i < 4; i++) begin
        if (b[i]) mdl[d][idx][8*i +: 8] = wd[8*i +: 8];
      end
    end
    if (r && w) exp_perr[d] = 1'b1;
    if (!inr) exp_oerr[d] = 1'b1;
    check($sformatf("perr%0d", d), perr[d], exp_perr[d]);
    check($sformatf("oerr%0d", d), oerr[d], exp_oerr[d]);
    // Idle cycle after the response: busy back high, rdata held.
    @(negedge clk);
    check($sformatf("post_busy%0d", d), busy[d], 32'd1);
    check($sformatf("hold_rdata%0d", d), rdata[d], last_rd[d]);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin : stim
    logic [31:0] rd;
    logic [31:0] a;
    int d;
    int k;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; addr[i] = 32'd0; wdata[i] = 32'd0; be[i] = 4'd0;
      ren[i] = 1'b0; wen[i] = 1'b0;
      exp_perr[i] = 1'b0; exp_oerr[i] = 1'b0; last_rd[i] = 32'd0;
    end
    repeat (2) @(posedge clk);
    do_reset(0);
    do_reset(1);

    // Fill both RAMs so every later read has a known expectation.
    for (int i = 0; i < DEP0; i++) txn(0, 1'b0, 1'b1, BASE0 + 32'(4 * i), $urandom, 4'hF, 1'b0, rd);
    for (int i = 0; i < DEP1; i++) txn(1, 1'b0, 1'b1, BASE1 + 32'(4 * i), $urandom, 4'hF, 1'b0, rd);

    // T1: full write then read back with two wait states.
    txn(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, rd);
    txn(0, 1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 1'b0, rd);
    check("t1_readback", rd, 32'hDEAD_BEEF);

    // T2: partial lane write.
    txn(0, 1'b0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 1'b0, rd);
    txn(0, 1'b0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0, rd);
    txn(0, 1'b0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 1'b0, rd);
    txn(0, 1'b1, 1'b0, 32'h20, 32'd0, 4'h0, 1'b0, rd);
    check("t2_partial", rd, 32'h11BB_33DD);

    // T3: address window of the 0x1000-based instance.
    txn(1, 1'b0, 1'b1, 32'h103C, 32'h0C0F_FEE0, 4'hF, 1'b0, rd);
    txn(1, 1'b1, 1'b0, 32'h1040, 32'd0, 4'h0, 1'b0, rd);
    check("t3_oor_rdata", rd, 32'hBAD1_BAD1);
    check("t3_oor_flag", oerr[1], 32'd1);
    txn(1, 1'b0, 1'b1, 32'h0FFC, 32'h5555_5555, 4'hF, 1'b0, rd);
    txn(1, 1'b1, 1'b0, 32'h103C, 32'd0, 4'h0, 1'b0, rd);
    check("t3_last_word", rd, 32'h0C0F_FEE0);
    do_reset(1);

    // T4: zero wait states with ren held across two transactions.
    @(negedge clk);
    addr[1] = 32'h1004; ren[1] = 1'b1; wen[1] = 1'b0;
    @(posedge clk); @(negedge clk);
    check("t4_resp1_busy", busy[1], 32'd0);
    check("t4_resp1_rdata", rdata[1], mdl[1][1]);
    @(posedge clk); @(negedge clk);
    check("t4_gap_busy", busy[1], 32'd1);
    @(posedge clk); @(negedge clk);
    check("t4_resp2_busy", busy[1], 32'd0);
    check("t4_resp2_rdata", rdata[1], mdl[1][1]);
    ren[1] = 1'b0;
    last_rd[1] = mdl[1][1];
    @(posedge clk); @(negedge clk);
    check("t4_idle_busy", busy[1], 32'd1);

    // T5: reset during WAIT of a write discards it.
    txn(0, 1'b0, 1'b1, 32'h30, 32'h0000_0000, 4'hF, 1'b0, rd);
    @(negedge clk);
    addr[0] = 32'h30; wdata[0] = 32'h7777_7777; be[0] = 4'hF; wen[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    wen[0] = 1'b0; rst[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    rst[0] = 1'b0;
    exp_perr[0] = 1'b0; exp_oerr[0] = 1'b0; last_rd[0] = 32'd0;
    check("t5_busy", busy[0], 32'd1);
    check("t5_rdata", rdata[0], 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_no_resp", busy[0], 32'd1);
    end
    txn(0, 1'b1, 1'b0, 32'h30, 32'd0, 4'h0, 1'b0, rd);
    check("t5_discarded", rd, 32'h0000_0000);

    // T6: ren&wen resolves to write; mid-WAIT address change ignored.
    txn(0, 1'b1, 1'b1, 32'h40, 32'hCAFE_F00D, 4'hF, 1'b1, rd);
    check("t6_perr", perr[0], 32'd1);
    txn(0, 1'b1, 1'b0, 32'h40, 32'd0, 4'h0, 1'b0, rd);
    check("t6_latched_addr", rd, 32'hCAFE_F00D);
    txn(0, 1'b1, 1'b0, 32'h44, 32'd0, 4'h0, 1'b0, rd);

    // Random traffic on both instances.
    for (int n = 0; n < 200; n++) begin
      d = $urandom_range(0, 1);
      k = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) begin
        if (d == 1 && $urandom_range(0, 1) == 1) a = BASE1 - 32'(4 * $urandom_range(1, 16));
        else a = 32'(base_of(d)) + 32'(4 * depth_of(d)) + 32'(4 * $urandom_range(0, 15));
      end else begin
        a = 32'(base_of(d)) + 32'(4 * $urandom_range(0, depth_of(d) - 1)) + 32'($urandom_range(0, 3));
      end
      txn(d, (k <= 3) || (k == 9), (k >= 4), a, $urandom, 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), rd);
    end

    // Sticky flags clear only on reset.
    do_reset(0);
    do_reset(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
